// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared mdu_op encodings and op-class helpers (MDU_MADD_EN adds the MADD/MSUB family)
package mult_div_unit_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;
  localparam logic [3:0] MDU_MSUB  = 4'd9;
  localparam logic [3:0] MDU_MSUBU = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Ops that take the multiply latency; accumulate forms only exist when enabled.
  function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_MADD) ||
           (op == MDU_MADDU) || (op == MDU_MSUB) || (op == MDU_MSUBU);
`else
    return (op == MDU_MULT) || (op == MDU_MULTU);
`endif
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle MIPS-style multiply/divide unit with HI/LO (MDU_MADD_EN enables MADD/MSUB)
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_e  state_q, state_d;
  logic [15:0] cnt_q;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;

  logic        is_md;
  logic        res_we;
  logic [63:0] res;
  logic [63:0] prod_u, prod_s;
  logic        div_ovf;
  logic [31:0] div_b;
  logic signed [31:0] q_s, r_s;
  logic [31:0] q_u, r_u;

  assign is_md = is_mul_op(mdu_op) || is_div_op(mdu_op);

  // Low 64 bits of the sign-extended product equal the signed 64-bit product.
  assign prod_u  = {32'b0, a_q} * {32'b0, b_q};
  assign prod_s  = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  // Substitute a divisor of 1 for the zero and overflow cases so the dividers never see them.
  assign div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign div_b   = ((b_q == 32'd0) || div_ovf) ? 32'd1 : b_q;
  assign q_s     = $signed(a_q) / $signed(div_b);
  assign r_s     = $signed(a_q) % $signed(div_b);
  assign q_u     = a_q / div_b;
  assign r_u     = a_q % div_b;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: accept a mult/div only while idle, leave RUN on the last count
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && is_md) state_d = ST_RUN;
      ST_RUN:  if (cnt_q <= 16'd1) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register only, so start never reaches busy combinationally
  always_comb begin
    busy = (state_q == ST_RUN);
  end

  // Result selection from the latched operands; divide-by-zero suppresses the write
  always_comb begin
    res    = {HI, LO};
    res_we = 1'b1;
    case (op_q)
      MDU_MULT:  res = prod_s;
      MDU_MULTU: res = prod_u;
      MDU_DIV: begin
        if (b_q == 32'd0) res_we = 1'b0;
        else if (div_ovf) res = {32'd0, 32'h8000_0000};
        else              res = {r_s, q_s};
      end
      MDU_DIVU: begin
        if (b_q == 32'd0) res_we = 1'b0;
        else              res = {r_u, q_u};
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  res = {HI, LO} + prod_s;
      MDU_MADDU: res = {HI, LO} + prod_u;
      MDU_MSUB:  res = {HI, LO} - prod_s;
      MDU_MSUBU: res = {HI, LO} - prod_u;
`endif
      default:   res_we = 1'b0;
    endcase
  end

  // Operand latch, busy counter and HI/LO commit; MTHI/MTLO only while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 16'd0;
      op_q  <= MDU_NONE;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else if (state_q == ST_IDLE) begin
      if (start && is_md) begin
        a_q   <= A;
        b_q   <= B;
        op_q  <= mdu_op;
        cnt_q <= is_mul_op(mdu_op) ? 16'(MULT_CYCLES) : 16'(DIV_CYCLES);
      end else if (start && (mdu_op == MDU_MTHI)) begin
        HI <= A;
      end else if (start && (mdu_op == MDU_MTLO)) begin
        LO <= A;
      end
    end else begin
      cnt_q <= cnt_q - 16'd1;
      if ((cnt_q <= 16'd1) && res_we) {HI, LO} <= res;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed scoreboard bench for mult_div_unit
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  mdu_op = MDU_NONE;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;
  logic [63:0] sb[$];

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a mult/div, optionally inject an ignored start mid-run, then score HI/LO when busy falls.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int ncyc, input bit inject);
    int n;
    logic [63:0] e;
    sb.push_back({eh, el});
    mdu_op = op; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = $urandom; B = $urandom;
    check({tag, "_hold_hi"}, {32'd0, HI}, {32'd0, hi_m});
    check({tag, "_hold_lo"}, {32'd0, LO}, {32'd0, lo_m});
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (inject && n == 2) begin
        start = 1'b1; mdu_op = MDU_DIV; A = 32'd100; B = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_busy_cycles"}, 64'(n), 64'(ncyc));
    e = sb.pop_front();
    check({tag, "_hi"}, {32'd0, HI}, {32'd0, e[63:32]});
    check({tag, "_lo"}, {32'd0, LO}, {32'd0, e[31:0]});
    hi_m = eh; lo_m = el;
  endtask

  // Single-cycle op (MTHI/MTLO or an ignored encoding): busy must stay low.
  task automatic single_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] eh, input logic [31:0] el);
    mdu_op = op; A = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_hi"}, {32'd0, HI}, {32'd0, eh});
    check({tag, "_lo"}, {32'd0, LO}, {32'd0, el});
    @(negedge clk);
    check({tag, "_busy2"}, {63'd0, busy}, 64'd0);
    hi_m = eh; lo_m = el;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hi", {32'd0, HI}, 64'd0);
    check("rst_lo", {32'd0, LO}, 64'd0);
    reset = 1'b1;

    run_op("mult",   MDU_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 0);
    run_op("multu",  MDU_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 5, 0);
    run_op("div",    MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0);
    run_op("divu0",  MDU_DIVU,  32'd7,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0);
    run_op("divovf", MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10, 0);
    run_op("divneg", MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10, 0);
    run_op("divu",   MDU_DIVU,  32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999, 10, 0);
    run_op("div0",   MDU_DIV,   32'd123,       32'd0,         32'd5,         32'h1999_9999, 10, 0);
    run_op("inject", MDU_MULT,  32'd2,         32'd3,         32'd0,         32'd6,         5, 1);

    single_op("mtlo", MDU_MTLO, 32'h0000_1234, 32'd0,         32'h0000_1234);
    single_op("mthi", MDU_MTHI, 32'h0000_ABCD, 32'h0000_ABCD, 32'h0000_1234);
    single_op("badop", 4'hF,    32'hDEAD_BEEF, 32'h0000_ABCD, 32'h0000_1234);

`ifdef MDU_MADD_EN
    single_op("m_hi", MDU_MTHI, 32'd0,         32'd0, 32'h0000_1234);
    single_op("m_lo", MDU_MTLO, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF);
    run_op("maddu", MDU_MADDU, 32'd1, 32'd1, 32'd1, 32'd0, 5, 0);
    run_op("msub",  MDU_MSUB,  32'd2, 32'hFFFF_FFFF, 32'd1, 32'd2, 5, 0);
`else
    single_op("maddu_off", MDU_MADDU, 32'd1, 32'h0000_ABCD, 32'h0000_1234);
    single_op("msub_off",  MDU_MSUB,  32'd1, 32'h0000_ABCD, 32'h0000_1234);
`endif

    // Reset in the middle of a divide clears everything without waiting for a clock edge.
    mdu_op = MDU_DIV; A = 32'd1000; B = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_busy_pre", {63'd0, busy}, 64'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_hi", {32'd0, HI}, 64'd0);
    check("mid_rst_lo", {32'd0, LO}, 64'd0);
    hi_m = 32'd0; lo_m = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    run_op("post_rst", MDU_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 5, 0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
